// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared definitions for the UART transmit path.
// Holds the sequencer state encoding and the common frame width default.
package uart_tx_fifo_pkg;

    // Default frame width shared with the transmitter and receiver
    localparam int FRAME_WD_DEF = 8;

    // Sequencer states; the encoding is fixed so debug tools can decode it
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host write port plus transmitter handshake bundle.
// Optional macro UART_TX_FIFO_LEVEL_EN adds the occupancy signal 'level'.
interface uart_tx_fifo_if #(
    parameter int FRAME_WD = 8
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    parameter int DEPTH_LOG2 = 4
`endif
);
    logic                wr_en;
    logic [FRAME_WD-1:0] wr_data;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                frame_en;
    logic [FRAME_WD-1:0] data_frame;
    logic                tx_done;
    logic                busy;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [DEPTH_LOG2:0] level;

    modport master (output wr_en, wr_data, tx_done,
                    input  full, empty, overflow, frame_en, data_frame, busy, level);
    modport slave  (input  wr_en, wr_data, tx_done,
                    output full, empty, overflow, frame_en, data_frame, busy, level);
`else
    modport master (output wr_en, wr_data, tx_done,
                    input  full, empty, overflow, frame_en, data_frame, busy);
    modport slave  (input  wr_en, wr_data, tx_done,
                    output full, empty, overflow, frame_en, data_frame, busy);
`endif
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with occupancy count and sticky overflow.
// A push while full is dropped (even with a same-cycle pop) and flags overflow.
module uart_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign full_s    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty_s   = (count_q == (DEPTH_LOG2+1)'(0));
    assign push_ok_s = push_i & ~full_s;
    assign pop_ok_s  = pop_i & ~empty_s;

    assign head_o     = mem_q[rd_ptr_q];
    assign full_o     = full_s;
    assign empty_o    = empty_s;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    // Storage array; contents need no reset because the pointers gate reads
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers, occupancy count and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + (DEPTH_LOG2+1)'(1);
                2'b01:   count_q <= count_q - (DEPTH_LOG2+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && full_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit buffer and frame sequencer ahead of the UART TX.
// Pops one byte per transmitter completion, pulses frame_en for one cycle,
// and optionally idles GAP_CYCLES clocks between frames.
// Optional macro UART_TX_FIFO_LEVEL_EN exposes the occupancy as bus.level.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int FRAME_WD   = FRAME_WD_DEF,
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    tx_state_e           state_q;
    tx_state_e           state_d;
    logic [FRAME_WD-1:0] data_frame_q;
    logic [FRAME_WD-1:0] data_frame_d;
    logic [15:0]         gap_cnt_q;
    logic [15:0]         gap_cnt_d;
    logic                tx_done_q;
    logic                tx_edge_s;
    logic                pop_s;
    logic [FRAME_WD-1:0] head_s;
    logic                full_s;
    logic                empty_s;
    logic                overflow_s;
    logic [DEPTH_LOG2:0] count_s;

    uart_sync_fifo #(
        .WIDTH      (FRAME_WD),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.wr_en),
        .push_data_i (bus.wr_data),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .count_o     (count_s),
        .overflow_o  (overflow_s)
    );

    // A held-high tx_done produces a single edge
    assign tx_edge_s = bus.tx_done & ~tx_done_q;

    // Sequencer next-state, FIFO pop and frame/gap-counter loads
    always_comb begin
        state_d      = state_q;
        data_frame_d = data_frame_q;
        gap_cnt_d    = gap_cnt_q;
        pop_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_s != (DEPTH_LOG2+1)'(0)) begin
                    pop_s        = 1'b1;
                    data_frame_d = head_s;
                    state_d      = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_edge_s) begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = 16'(GAP_CYCLES - 1);
                        state_d   = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, frame register, gap counter and tx_done history
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            data_frame_q <= '0;
            gap_cnt_q    <= 16'd0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_frame_q <= data_frame_d;
            gap_cnt_q    <= gap_cnt_d;
            tx_done_q    <= bus.tx_done;
        end
    end

    assign bus.frame_en   = (state_q == ST_START);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.data_frame = data_frame_q;
    assign bus.full       = full_s;
    assign bus.empty      = empty_s;
    assign bus.overflow   = overflow_s;
`ifdef UART_TX_FIFO_LEVEL_EN
    assign bus.level      = count_s;
`endif

endmodule
